clkdiv_ratio_ctrl: RTL and testbench
====================================

// Module: clkdiv_ratio_ctrl
// PURPOSE
//  Sequences and arbitrates ratio changes for one ClkDiv instance. Two requesters
//  (req0: register-file config, req1: autobaud/secondary) ask for a new division ratio.
//  Each change runs a gate -> reset -> reload -> settle -> enable sequence, so the
//  divider never runs with a stale counter against a new ratio. The block sits beside
//  ClkDiv and drives its ratio, enable and reset inputs.
// PARAMETERS
//  RATIO_WD    8   width of the division ratio (matches ClkDiv RATIO_WD)
//  INIT_RATIO  8   ratio loaded after i_rst; 0 is illegal
//  GATE_CYC    2   cycles o_div_clk_en is held low before the divider reset (>=1)
//  SETTLE_CYC  2   cycles after divider reset release before re-enable (>=1)
// PORTS
//  i_ref_clk     in   1         reference clock; same clock as ClkDiv
//  i_rst         in   1         asynchronous, active-low reset
//  i_en          in   1         global divider enable, applied only in IDLE
//  i_req0        in   1         requester 0 change request, level
//  i_ratio0      in   RATIO_WD  requester 0 ratio; stable while i_req0 is high
//  o_ack0        out  1         one-cycle completion pulse to requester 0
//  i_req1        in   1         requester 1 change request, level
//  i_ratio1      in   RATIO_WD  requester 1 ratio; stable while i_req1 is high
//  o_ack1        out  1         one-cycle completion pulse to requester 1
//  o_err         out  1         valid with o_ackN: 1 = request rejected (ratio 0)
//  o_div_ratio   out  RATIO_WD  ratio to ClkDiv i_div_ratio; registered
//  o_div_clk_en  out  1         to ClkDiv i_clk_en; registered
//  o_div_rst_n   out  1         to ClkDiv i_rst, active-low; registered, glitch-free
//  o_busy        out  1         1 in any state other than IDLE
// BEHAVIOUR
//  Reset values: state=RST, o_div_ratio=INIT_RATIO, o_div_clk_en=0, o_div_rst_n=0,
//   o_ack0/1=0, o_err=0, o_busy=1, rr_ptr=0, no grant held.
//  FSM states: IDLE, GATE, RST, SETTLE, DONE.
//  IDLE: o_div_clk_en=i_en (registered, so it follows with 1 cycle of lag).
//   The state samples requests on every edge.
//   - One req high: grant it. Both high: grant rr_ptr (0 -> req0); rr_ptr <= ~granted.
//   - Granted ratio == 0: go to DONE with err=1. Divider outputs are untouched.
//   - Granted ratio == o_div_ratio: go to DONE with err=0 and no gating (fast path).
//   - Otherwise: latch the ratio into new_ratio and go to GATE.
//  GATE: o_div_clk_en=0 for GATE_CYC cycles, then go to RST.
//  RST: o_div_rst_n=0 for exactly 1 cycle; o_div_ratio<=new_ratio. Then go to SETTLE.
//  SETTLE: o_div_rst_n=1, o_div_clk_en=0 for SETTLE_CYC cycles. Then go to DONE.
//  DONE: o_ackN=1 for the granted requester only, o_err per the grant, and
//   o_div_clk_en<=i_en. Then go to IDLE. After the post-reset sequence DONE pulses
//   no ack.
//  Latency: if a request is sampled at edge E0, ack is high in the cycle after edge
//   E0+GATE_CYC+SETTLE_CYC+2 (defaults: 6 cycles). Fast path and error path ack in
//   the cycle after E0.
//  Handshake: the requester holds reqN and ratioN until ackN, then drops reqN for at
//   least 1 cycle. A req still high in the cycle after ack is a new request.
//  A req that drops before grant is lost, with no ack. Changes to ratio or req after
//   grant are ignored until DONE.
//  i_en changes during GATE/RST/SETTLE are ignored; they are applied in DONE/IDLE.
//  Ratio 1 is legal: ClkDiv bypasses to i_ref_clk. The full sequence still runs.
//  Cycle counter is $clog2(max(GATE_CYC,SETTLE_CYC)+1) bits. It is cleared on every
//   state entry and never wraps.
//  Reset asserted mid-sequence: everything returns to reset values at once and the
//   pending grant is dropped with no ack. The requester must re-request.
//  Only one grant is outstanding at a time. The losing requester waits in IDLE, and
//   the next IDLE edge grants it.
// TESTING
//  1 Release reset, i_en=1 -> o_div_rst_n low 1 cycle, then high; o_div_clk_en=1
//    after SETTLE+DONE; o_div_ratio=8; no ack.
//  2 i_req0=1, i_ratio0=5 -> o_div_clk_en low 2 cycles, o_div_rst_n pulse, ratio=5,
//    o_ack0 after 6 cycles, o_err=0; ClkDiv output period = 5 ref cycles.
//  3 i_req0 and i_req1 rise together (ratios 4 and 6) -> req0 acked first (ratio 4),
//    then req1 (ratio 6). Repeat the pair -> req1 is served first.
//  4 i_req1=1, i_ratio1=0 -> o_ack1 plus o_err in the next cycle; ratio, enable and
//    divider reset unchanged.
//  5 Request ratio equal to the current ratio -> ack in the next cycle, no o_div_rst_n
//    pulse, o_div_clk_en stays high.
//  6 Assert i_rst during SETTLE -> all outputs return to reset values, no ack;
//    after release the INIT_RATIO sequence runs again.

Source files
------------

// File: rtl/clkdiv_ratio_ctrl.sv
// Ratio-change sequencer for one ClkDiv: arbitrates two requesters and runs
// gate -> reset -> reload -> settle -> enable so a new ratio never meets a stale counter.
module clkdiv_ratio_ctrl #(
  parameter int RATIO_WD   = 8,
  parameter int INIT_RATIO = 8,
  parameter int GATE_CYC   = 2,
  parameter int SETTLE_CYC = 2
) (
  input  logic                i_ref_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic                i_req0,
  input  logic [RATIO_WD-1:0] i_ratio0,
  output logic                o_ack0,
  input  logic                i_req1,
  input  logic [RATIO_WD-1:0] i_ratio1,
  output logic                o_ack1,
  output logic                o_err,
  output logic [RATIO_WD-1:0] o_div_ratio,
  output logic                o_div_clk_en,
  output logic                o_div_rst_n,
  output logic                o_busy
);

  // state  | meaning
  // IDLE   | divider running, arbitrate requests
  // GATE   | divider clock enable held low
  // RST    | divider reset asserted, new ratio loaded
  // SETTLE | reset released, enable still low
  // DONE   | ack/err to granted requester, enable restored
  localparam int MAX_CYC = (GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC;
  localparam int CNT_WD  = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GATE,
    ST_RST,
    ST_SETTLE,
    ST_DONE
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_WD-1:0]   cnt;
  logic                rr_ptr;
  logic                gnt;
  logic                gnt_vld;
  logic                err;
  logic [RATIO_WD-1:0] new_ratio;
  logic                req_any;
  logic                pick;
  logic [RATIO_WD-1:0] pick_ratio;

  always_ff @(posedge i_ref_clk or negedge i_rst) begin
    if (!i_rst) state <= ST_RST;
    else        state <= state_nxt;
  end

  always_comb begin
    req_any = i_req0 | i_req1;
    pick    = 1'b0;
    if (i_req0 && i_req1) pick = rr_ptr;
    else if (i_req1)      pick = 1'b1;
    pick_ratio = pick ? i_ratio1 : i_ratio0;
  end

  // The divider reset register lags the state by one cycle, so SETTLE spends one
  // extra cycle to give SETTLE_CYC full cycles after the reset is released.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_any) begin
          if (pick_ratio == '0 || pick_ratio == o_div_ratio) state_nxt = ST_DONE;
          else                                               state_nxt = ST_GATE;
        end
      end
      ST_GATE:   if (cnt == CNT_WD'(GATE_CYC - 1)) state_nxt = ST_RST;
      ST_RST:    state_nxt = ST_SETTLE;
      ST_SETTLE: if (cnt == CNT_WD'(SETTLE_CYC)) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_RST;
    endcase
  end

  always_comb begin
    o_busy = (state != ST_IDLE);
    o_ack0 = (state == ST_DONE) && gnt_vld && !gnt;
    o_ack1 = (state == ST_DONE) && gnt_vld && gnt;
    o_err  = (state == ST_DONE) && gnt_vld && err;
  end

  always_ff @(posedge i_ref_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= '0;
    end else if (state == ST_GATE || state == ST_SETTLE) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge i_ref_clk or negedge i_rst) begin
    if (!i_rst) begin
      rr_ptr    <= 1'b0;
      gnt       <= 1'b0;
      gnt_vld   <= 1'b0;
      err       <= 1'b0;
      new_ratio <= RATIO_WD'(INIT_RATIO);
    end else if (state == ST_IDLE && req_any) begin
      gnt     <= pick;
      gnt_vld <= 1'b1;
      err     <= (pick_ratio == '0);
      if (state_nxt == ST_GATE) new_ratio <= pick_ratio;
      if (i_req0 && i_req1) rr_ptr <= ~pick;
    end else if (state == ST_DONE) begin
      gnt_vld <= 1'b0;
    end
  end

  always_ff @(posedge i_ref_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_div_ratio  <= RATIO_WD'(INIT_RATIO);
      o_div_clk_en <= 1'b0;
      o_div_rst_n  <= 1'b0;
    end else begin
      o_div_rst_n  <= (state != ST_RST);
      o_div_clk_en <= (state == ST_IDLE || state == ST_DONE) ? i_en : 1'b0;
      if (state == ST_RST) o_div_ratio <= new_ratio;
    end
  end

endmodule

// File: tb/tb_clkdiv_ratio_ctrl.sv
// Directed bench for clkdiv_ratio_ctrl: startup, full/fast/error paths,
// round-robin contention, ratio 1 and mid-sequence reset.
module tb_clkdiv_ratio_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic       req0;
  logic [7:0] ratio0;
  logic       ack0;
  logic       req1;
  logic [7:0] ratio1;
  logic       ack1;
  logic       err;
  logic [7:0] div_ratio;
  logic       div_clk_en;
  logic       div_rst_n;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;

  clkdiv_ratio_ctrl dut (
    .i_ref_clk   (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_req0      (req0),
    .i_ratio0    (ratio0),
    .o_ack0      (ack0),
    .i_req1      (req1),
    .i_ratio1    (ratio1),
    .o_ack1      (ack1),
    .o_err       (err),
    .o_div_ratio (div_ratio),
    .o_div_clk_en(div_clk_en),
    .o_div_rst_n (div_rst_n),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called right after reset release at a negedge; the INIT_RATIO sequence takes 5 edges.
  task automatic check_startup(input string tag);
    int rst_low = 0;
    int en_high = 0;
    int busy_hi = 0;
    int acks    = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!div_rst_n) rst_low++;
      if (div_clk_en) en_high++;
      if (busy) busy_hi++;
      if (ack0 || ack1 || err) acks++;
    end
    check({tag, "_rst_low"}, rst_low, 1);
    check({tag, "_en_high"}, en_high, 1);
    check({tag, "_busy_cyc"}, busy_hi, 4);
    check({tag, "_no_ack"}, acks, 0);
    check({tag, "_ratio"}, div_ratio, 8);
    check({tag, "_idle"}, busy, 0);
  endtask

  // Request must already be driven; first tick is the sampling edge E0.
  task automatic await_ack(input string tag, input int which, input int exp_lat,
                           input int exp_err, input int exp_ratio, input int exp_rst_idx,
                           input int exp_en_low);
    int  k       = 0;
    int  rst_low = 0;
    int  rst_idx = -1;
    int  en_low  = 0;
    int  other   = 0;
    bit  done    = 0;
    tick();
    while (!done) begin
      if (!div_rst_n) begin
        rst_low++;
        if (rst_idx < 0) rst_idx = k;
      end
      if (!div_clk_en) en_low++;
      if (which == 0 ? ack1 : ack0) other++;
      if ((which == 0 ? ack0 : ack1) || k >= 30) done = 1;
      else begin
        tick();
        k++;
      end
    end
    check({tag, "_lat"}, k, exp_lat);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_ratio"}, div_ratio, exp_ratio);
    check({tag, "_rst_idx"}, rst_idx, exp_rst_idx);
    check({tag, "_rst_low"}, rst_low, (exp_rst_idx < 0) ? 0 : 1);
    check({tag, "_en_low"}, en_low, exp_en_low);
    check({tag, "_other_ack"}, other, 0);
    if (which == 0) req0 = 1'b0;
    else            req1 = 1'b0;
    tick();
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_en_after"}, div_clk_en, 1);
    check({tag, "_ack_cleared"}, ack0 | ack1, 0);
  endtask

  initial begin
    rst    = 1'b0;
    en     = 1'b1;
    req0   = 1'b0;
    req1   = 1'b0;
    ratio0 = 8'd0;
    ratio1 = 8'd0;
    repeat (3) tick();
    check("rst_ratio", div_ratio, 8);
    check("rst_clk_en", div_clk_en, 0);
    check("rst_div_rst_n", div_rst_n, 0);
    check("rst_busy", busy, 1);
    check("rst_ack", ack0 | ack1, 0);
    check("rst_err", err, 0);

    rst = 1'b1;
    check_startup("start");

    req0 = 1'b1; ratio0 = 8'd5;
    await_ack("r0_5", 0, 6, 0, 5, 3, 6);

    req0 = 1'b1; ratio0 = 8'd4;
    req1 = 1'b1; ratio1 = 8'd6;
    await_ack("pair1_r0", 0, 6, 0, 4, 3, 6);
    await_ack("pair1_r1", 1, 6, 0, 6, 3, 6);

    req0 = 1'b1; ratio0 = 8'd4;
    req1 = 1'b1; ratio1 = 8'd6;
    await_ack("pair2_r1", 1, 0, 0, 6, -1, 0);
    await_ack("pair2_r0", 0, 6, 0, 4, 3, 6);

    req1 = 1'b1; ratio1 = 8'd0;
    await_ack("zero_r1", 1, 0, 1, 4, -1, 0);

    req0 = 1'b1; ratio0 = 8'd4;
    await_ack("same_r0", 0, 0, 0, 4, -1, 0);

    req1 = 1'b1; ratio1 = 8'd1;
    await_ack("one_r1", 1, 6, 0, 1, 3, 6);

    en = 1'b0;
    tick();
    check("en_off", div_clk_en, 0);
    en = 1'b1;
    tick();
    check("en_on", div_clk_en, 1);

    req0 = 1'b1; ratio0 = 8'd9;
    repeat (4) tick();
    check("mid_busy", busy, 1);
    check("mid_ratio_loaded", div_ratio, 9);
    rst = 1'b0;
    req0 = 1'b0;
    #1;
    check("mid_rst_ratio", div_ratio, 8);
    check("mid_rst_clk_en", div_clk_en, 0);
    check("mid_rst_div_rst_n", div_rst_n, 0);
    check("mid_rst_busy", busy, 1);
    check("mid_rst_ack", ack0 | ack1 | err, 0);
    tick();
    tick();
    check("mid_hold_ack", ack0 | ack1, 0);
    rst = 1'b1;
    check_startup("restart");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
